io_dir_seq: RTL and testbench
=============================

IO_DIR_SEQ -- requirements
Module: io_dir_seq

Interface
REQ-001 SHALL have parameter NUM_PADS, default 4: number of io1bit pads sequenced (1..16).
REQ-002 SHALL have parameter TURN_W, default 4: width of the turnaround count field.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port config_en, input, 1: config write strobe, valid for one cycle.
REQ-006 SHALL have port config_addr, input, 32: config address; [15:0] tile select, [23:16] register select.
REQ-007 SHALL have port config_data, input, 32: config write data.
REQ-008 SHALL have port tile_id, input, 16: this tile's id; quasi-static.
REQ-009 SHALL have port mode, output, NUM_PADS: per-pad drive enable feeding io1bit mode (1 = drive f2p onto pad, 0 = high-Z).
REQ-010 SHALL have port busy, output, 1: high while a turnaround is in progress.
REQ-011 SHALL have port cfg_drop, output, 1: one-cycle pulse when a matching write is rejected.

Function
REQ-012 SHALL treat a write as matching when config_en=1, config_addr[15:0]==tile_id and config_addr[23:16]==8'd0; all other writes have no effect and produce no cfg_drop.
REQ-013 SHALL decode matching-write fields as: target = config_data[NUM_PADS-1:0]; turn = config_data[8+TURN_W-1:8]; all other bits ignored.
REQ-014 SHALL implement states IDLE and TURN; busy=1 exactly when state is TURN.
REQ-015 SHALL accept a matching write only in IDLE; accepted in cycle T, it latches target, turn and rise = target & ~mode.
REQ-016 SHALL, when rise==0 or turn==0, drive mode=target from cycle T+1 and remain in IDLE.
REQ-017 SHALL otherwise enter TURN for exactly turn cycles (T+1 .. T+turn), drive mode = old_mode & target during them, then drive mode=target and return to IDLE from cycle T+turn+1.
REQ-018 SHALL therefore release pads leaving output mode (1->0) at T+1 in all cases; only pads entering output mode (0->1) wait out the turnaround.
REQ-019 SHALL never drive a rising pad's mode bit to 1 before cycle T+turn+1; no glitches on unchanged bits.
REQ-020 SHALL ignore a matching write arriving during TURN, leave target, counter and mode unchanged, and assert cfg_drop for the following cycle.
REQ-021 SHALL count turn with a TURN_W-bit down-counter; max turn 2^TURN_W-1; no wrap; counter not reloaded mid-TURN.
REQ-022 SHALL complete normally on a write whose target equals the current mode (mode unchanged, no TURN, busy stays 0).
REQ-023 SHALL accept a new matching write in the same cycle that TURN's final cycle ends (first IDLE cycle).

Reset
REQ-024 SHALL on reset=1 immediately (asynchronously) force mode=0, busy=0, cfg_drop=0, state=IDLE, counter=0, target=0.
REQ-025 SHALL abandon any in-progress TURN on reset with no pending mode change after release.
REQ-026 SHALL accept a matching write on the first rising clk edge after reset deasserts.

Verification
REQ-027 SHALL pass: after reset, tile_id=0x0005, write addr=0x00000005 data=0x0000_0303 (target=4'b0011, turn=3) in cycle T -> mode=0000 and busy=1 in T+1..T+3, mode=0011 and busy=0 from T+4.
REQ-028 SHALL pass: from mode=0011, write data=0x0000_0501 (target=0001, turn=5) -> mode=0001 at T+1, busy stays 0.
REQ-029 SHALL pass: from mode=0001, write data=0x0000_0206 (target=0110, turn=2) -> mode=0000 in T+1..T+2, mode=0110 at T+3.
REQ-030 SHALL pass: during the TURN of REQ-027, a second matching write data=0x000F -> cfg_drop=1 for one cycle, sequence completes with mode=0011 at T+4.
REQ-031 SHALL pass: write with addr=0x00000006 or addr=0x00010005 -> no change to mode, busy, or cfg_drop.
REQ-032 SHALL pass: reset asserted mid-TURN between clock edges -> mode=0 and busy=0 without waiting for a clk edge; after release, mode stays 0 until the next matching write.

Source files
------------

// File: rtl/io_dir_seq.sv
// Pad direction sequencer: applies configured io1bit drive enables, releasing
// pads immediately and holding newly driven pads off for a turnaround period.
module io_dir_seq #(
   parameter int unsigned NUM_PADS = 4,
   parameter int unsigned TURN_W   = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                config_en,
   input  logic [31:0]         config_addr,
   input  logic [31:0]         config_data,
   input  logic [15:0]         tile_id,
   output logic [NUM_PADS-1:0] mode,
   output logic                busy,
   output logic                cfg_drop
);

   typedef enum logic {IDLE, TURN} state_t;

   state_t              state, state_nx;
   logic [TURN_W-1:0]   cnt, cnt_nx;
   logic [NUM_PADS-1:0] target, target_nx, mode_nx;
   logic [NUM_PADS-1:0] wr_target, rise;
   logic [TURN_W-1:0]   wr_turn;
   logic                match, drop_nx;
   logic                unused_bits;

   assign match     = config_en && (config_addr[15:0] == tile_id) && (config_addr[23:16] == 8'd0);
   assign wr_target = config_data[NUM_PADS-1:0];
   assign wr_turn   = config_data[8+TURN_W-1:8];
   assign rise      = wr_target & ~mode;
   assign busy      = (state == TURN);
   assign unused_bits = ^{config_addr[31:24], config_data};

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      target_nx = target;
      mode_nx   = mode;
      drop_nx   = 1'b0;
      case (state)
         IDLE: begin
            if (match) begin
               target_nx = wr_target;
               if (rise == '0 || wr_turn == '0) begin
                  mode_nx = wr_target;
               end else begin
                  // falling pads release now; rising pads wait for the count
                  state_nx = TURN;
                  cnt_nx   = wr_turn;
                  mode_nx  = mode & wr_target;
               end
            end
         end
         TURN: begin
            drop_nx = match;
            if (cnt == TURN_W'(1)) begin
               state_nx = IDLE;
               cnt_nx   = '0;
               mode_nx  = target;
            end else begin
               cnt_nx = cnt - TURN_W'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         target   <= '0;
         mode     <= '0;
         cfg_drop <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         target   <= target_nx;
         mode     <= mode_nx;
         cfg_drop <= drop_nx;
      end
   end

endmodule

// File: tb/tb_io_dir_seq.sv
// Bench for io_dir_seq: directed vector table, hand-written corner sequences,
// then random traffic against a timeline-based reference model.
module tb_io_dir_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        config_en = 1'b0;
   logic [31:0] config_addr = '0;
   logic [31:0] config_data = '0;
   logic [15:0] tile_id = 16'h0005;
   logic [3:0]  mode;
   logic        busy;
   logic        cfg_drop;

   int checks = 0;
   int errors = 0;

   io_dir_seq #(.NUM_PADS(4), .TURN_W(4)) dut (
      .clk(clk), .reset(reset), .config_en(config_en), .config_addr(config_addr),
      .config_data(config_data), .tile_id(tile_id), .mode(mode), .busy(busy),
      .cfg_drop(cfg_drop)
   );

   always #5 clk = ~clk;

   // Reference: remembers the last accepted write (cycle, old mode, target, turn)
   // and derives outputs of any later cycle from that record.
   int       n = 0;
   bit       have = 0;
   bit [3:0] m_old, m_tgt;
   int       m_turn, m_acc;
   bit       m_drop = 0;

   function automatic bit slow();
      return have && ((m_tgt & ~m_old) != 4'd0) && (m_turn != 0);
   endfunction

   function automatic bit exp_busy(int k);
      return slow() && (k >= m_acc + 1) && (k <= m_acc + m_turn);
   endfunction

   function automatic bit [3:0] exp_mode(int k);
      if (!have) return 4'd0;
      if (slow() && k <= m_acc + m_turn) return m_old & m_tgt;
      return m_tgt;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, return at the next negedge.
   task automatic step(input logic en, input logic [31:0] addr, input logic [31:0] data);
      bit match, b;
      config_en = en; config_addr = addr; config_data = data;
      @(posedge clk);
      match = en && (addr[15:0] == tile_id) && (addr[23:16] == 8'd0);
      b = exp_busy(n);
      m_drop = match && b;
      if (match && !b) begin
         m_old = exp_mode(n);
         m_tgt = data[3:0];
         m_turn = int'(data[11:8]);
         m_acc = n;
         have = 1;
      end
      n++;
      @(negedge clk);
      config_en = 1'b0;
   endtask

   task automatic do_reset();
      config_en = 1'b0;
      reset = 1'b1;
      #1;
      chk("rst_async", {mode, busy, cfg_drop}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      have = 0;
      m_drop = 0;
   endtask

   typedef struct {
      logic        en;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mode;
      logic        busy;
      logic        drop;
   } vec_t;

   vec_t vt[12];
   int   cnt;
   bit   early;

   initial begin
      vt[0]  = '{1'b1, 32'h0000_0005, 32'h0000_0303, 4'b0000, 1'b1, 1'b0};
      vt[1]  = '{1'b1, 32'h0000_0005, 32'h0000_000F, 4'b0000, 1'b1, 1'b1};
      vt[2]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b0};
      vt[3]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0011, 1'b0, 1'b0};
      vt[4]  = '{1'b1, 32'h0000_0005, 32'h0000_0501, 4'b0001, 1'b0, 1'b0};
      vt[5]  = '{1'b1, 32'h0000_0005, 32'h0000_0206, 4'b0000, 1'b1, 1'b0};
      vt[6]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b0};
      vt[7]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0110, 1'b0, 1'b0};
      vt[8]  = '{1'b1, 32'h0000_0006, 32'h0000_000F, 4'b0110, 1'b0, 1'b0};
      vt[9]  = '{1'b1, 32'h0001_0005, 32'h0000_000F, 4'b0110, 1'b0, 1'b0};
      vt[10] = '{1'b1, 32'h0000_0005, 32'h0000_0001, 4'b0001, 1'b0, 1'b0};
      vt[11] = '{1'b1, 32'h0000_0005, 32'h0000_0501, 4'b0001, 1'b0, 1'b0};

      #2;
      do_reset();

      for (int i = 0; i < 12; i++) begin
         step(vt[i].en, vt[i].addr, vt[i].data);
         chk($sformatf("vec%0d_mode", i), mode, vt[i].mode);
         chk($sformatf("vec%0d_busy", i), busy, vt[i].busy);
         chk($sformatf("vec%0d_drop", i), cfg_drop, vt[i].drop);
      end

      // write in the last TURN cycle is dropped; one in the first IDLE cycle lands
      step(1'b1, 32'h5, 32'h0000_020F);
      chk("b2b_t1", {mode, busy}, {4'b0001, 1'b1});
      step(1'b0, 32'h0, 32'h0);
      chk("b2b_t2", {mode, busy}, {4'b0001, 1'b1});
      step(1'b1, 32'h5, 32'h0000_0100);
      chk("b2b_t3", {mode, busy, cfg_drop}, {4'b1111, 1'b0, 1'b1});
      step(1'b1, 32'h5, 32'h0000_0100);
      chk("b2b_t4", {mode, busy, cfg_drop}, {4'b0000, 1'b0, 1'b0});

      // maximum turnaround, no early rise
      step(1'b1, 32'h5, 32'h0000_0F0F);
      cnt = 0;
      early = 0;
      while (busy && cnt < 40) begin
         if (mode != 4'd0) early = 1;
         cnt++;
         step(1'b0, 32'h0, 32'h0);
      end
      chk("maxturn_len", cnt, 32'd15);
      chk("maxturn_early", {31'd0, early}, 32'd0);
      chk("maxturn_mode", mode, 32'hF);

      // asynchronous reset in the middle of a turnaround
      step(1'b1, 32'h5, 32'h0000_0503);
      chk("fall_only", {mode, busy}, {4'b0011, 1'b0});
      step(1'b1, 32'h5, 32'h0000_040C);
      chk("pre_rst", {mode, busy}, {4'b0000, 1'b1});
      #2;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 32'h0, 32'h0);
         chk("post_rst_idle", {mode, busy, cfg_drop}, 32'd0);
      end
      step(1'b1, 32'h5, 32'h0000_0301);
      chk("post_rst_wr", {mode, busy}, {4'b0000, 1'b1});

      // random traffic against the reference model
      do_reset();
      for (int i = 0; i < 600; i++) begin
         logic [31:0] a, d;
         if ($urandom_range(0, 149) == 0) do_reset();
         case ($urandom_range(0, 5))
            0:       a = 32'h0000_0006;
            1:       a = 32'h0001_0005;
            default: a = 32'h0000_0005;
         endcase
         d = $urandom;
         step(1'($urandom_range(0, 2) != 0), a, d);
         chk("rnd_mode", mode, exp_mode(n));
         chk("rnd_busy", busy, exp_busy(n));
         chk("rnd_drop", cfg_drop, m_drop);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
